// File: rtl/frame_deserializer_if.sv
// ---------------------------------------------------------------------------
// frame_deserializer_if
// Bundles the serial input side and the parallel result side of
// frame_deserializer.
//   in_en      : bit qualifier; data_in is sampled only when high
//   data_in    : serial test stream
//   data_out   : last accepted payload word
//   data_valid : one-cycle strobe, data_out updated
//   locked     : high while a payload is being received after sync
//   parity_err : one-cycle strobe on a rejected frame (parity build only)
//   frame_cnt  : number of accepted frames, wraps
// Modports: master drives the stream and observes results; slave is the
// deserializer itself.
// ---------------------------------------------------------------------------
interface frame_deserializer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              in_en;
  logic              data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              locked;
  logic              parity_err;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output in_en, data_in,
    input  data_out, data_valid, locked, parity_err, frame_cnt
  );

  modport slave (
    input  in_en, data_in,
    output data_out, data_valid, locked, parity_err, frame_cnt
  );
endinterface

// File: rtl/frame_deserializer.sv
// ---------------------------------------------------------------------------
// frame_deserializer
// Serial-to-parallel front end of the 3D layer self-test path. Hunts the
// serial stream for SYNC_PAT with a sliding bit-by-bit compare, then
// assembles the next DATA_W bits MSB-first into one word, strobing
// data_valid for one cycle and counting accepted frames.
//
// Ports:
//   clk   : test clock
//   rst_n : asynchronous active-low reset
//   bus   : frame_deserializer_if.slave (in_en, data_in, data_out,
//           data_valid, locked, parity_err, frame_cnt)
//
// Build option: define PARITY_CHK_EN to expect one even-parity bit after
// each payload; frames failing the check pulse parity_err instead of
// data_valid. Without it parity_err is tied low.
// ---------------------------------------------------------------------------
module frame_deserializer #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       SYNC_W   = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  frame_deserializer_if.slave bus
);

  localparam int unsigned     BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  // Only the bits that can still reach a compare or the output are stored:
  // the sync register keeps SYNC_W-1 history bits (the live data_in completes
  // the window), and the data register keeps DATA_W-1 bits unless the word
  // must be held whole while the parity bit arrives.
`ifdef PARITY_CHK_EN
  localparam int unsigned DSR_W = DATA_W;
  typedef enum logic [1:0] {HUNT, RECV, PAR} state_t;
`else
  localparam int unsigned DSR_W = DATA_W - 1;
  typedef enum logic [0:0] {HUNT, RECV} state_t;
`endif

  state_t            state, state_n;
  logic [SYNC_W-2:0] sync_sr, sync_n;
  logic [DSR_W-1:0]  dsr, dsr_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] data_out_r, data_out_n;
  logic              valid_r, valid_n;
  logic              locked_r, locked_n;
  logic [CNT_W-1:0]  frame_cnt_r, frame_cnt_n;
`ifdef PARITY_CHK_EN
  logic              perr_r, perr_n;
`endif

  logic [SYNC_W-1:0] sync_shift;
  logic [DATA_W-1:0] dsr_shift;
  logic              accept;
  logic [DATA_W-1:0] accept_word;

  assign sync_shift = {sync_sr, bus.data_in};
  assign dsr_shift  = {dsr[DATA_W-2:0], bus.data_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      sync_sr     <= '0;
      dsr         <= '0;
      bit_cnt     <= '0;
      data_out_r  <= '0;
      valid_r     <= 1'b0;
      locked_r    <= 1'b0;
      frame_cnt_r <= '0;
`ifdef PARITY_CHK_EN
      perr_r      <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      sync_sr     <= sync_n;
      dsr         <= dsr_n;
      bit_cnt     <= bit_cnt_n;
      data_out_r  <= data_out_n;
      valid_r     <= valid_n;
      locked_r    <= locked_n;
      frame_cnt_r <= frame_cnt_n;
`ifdef PARITY_CHK_EN
      perr_r      <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    sync_n      = sync_sr;
    dsr_n       = dsr;
    bit_cnt_n   = bit_cnt;
    data_out_n  = data_out_r;
    valid_n     = 1'b0;
    frame_cnt_n = frame_cnt_r;
    accept      = 1'b0;
    accept_word = '0;
`ifdef PARITY_CHK_EN
    perr_n      = 1'b0;
`endif

    if (bus.in_en) begin
      case (state)
        HUNT: begin
          sync_n = sync_shift[SYNC_W-2:0];
          if (sync_shift == SYNC_PAT) begin
            state_n   = RECV;
            bit_cnt_n = '0;
          end
        end

        RECV: begin
          dsr_n     = dsr_shift[DSR_W-1:0];
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n = '0;
`ifdef PARITY_CHK_EN
            state_n   = PAR;
`else
            accept      = 1'b1;
            accept_word = dsr_shift;
            state_n     = HUNT;
            sync_n      = '0;
`endif
          end
        end

`ifdef PARITY_CHK_EN
        PAR: begin
          // Even parity: payload bits plus parity bit must XOR to zero.
          if (^{dsr, bus.data_in}) begin
            perr_n = 1'b1;
          end else begin
            accept      = 1'b1;
            accept_word = dsr;
          end
          state_n = HUNT;
          sync_n  = '0;
        end
`endif

        default: begin
          state_n = HUNT;
          sync_n  = '0;
        end
      endcase
    end

    if (accept) begin
      data_out_n  = accept_word;
      valid_n     = 1'b1;
      frame_cnt_n = frame_cnt_r + 1'b1;
    end

    locked_n = (state_n != HUNT);
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = valid_r;
  assign bus.locked     = locked_r;
  assign bus.frame_cnt  = frame_cnt_r;
`ifdef PARITY_CHK_EN
  assign bus.parity_err = perr_r;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
